// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response channel between fetch_unit (master) and imem (slave).
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_ready;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
    modport slave (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage PC owner issuing variable-latency imem requests into an in-order response FIFO.
// FETCH_BYPASS_EN: a response arriving at an empty FIFO drives the IF outputs in the same cycle.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC00000,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stallF,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    fetch_unit_if.master          imem,
    output logic                  validF,
    output logic [DATA_WIDTH-1:0] instrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];
    localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0]         out_q, out_d, drop_q, drop_d, count_q, count_d;
    logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [DATA_WIDTH-1:0] pc_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] ins_mem_q [FIFO_DEPTH];
    logic [CW:0]           inflight;
    logic                  accept, resp, keep, push, pop, fwd, head_valid;

    always_comb begin
        // stale responses still awaiting their drop count against the budget
        inflight       = {1'b0, out_q} + {1'b0, count_q};
        imem.imem_req  = rst_n && !redirect && (inflight < DEPTH_C);
        imem.imem_addr = fetch_pc_q;
        accept         = imem.imem_req && imem.imem_ready;
        resp           = imem.imem_rvalid && (out_q != '0);
        keep           = resp && (drop_q == '0) && !redirect;
        head_valid     = count_q != '0;
`ifdef FETCH_BYPASS_EN
        fwd            = keep && !head_valid;
`else
        fwd            = 1'b0;
`endif
        validF         = head_valid || fwd;
        pop            = head_valid && !stallF && !redirect;
        push           = keep && !(fwd && !stallF);
        PCF            = fwd ? resp_pc_q : head_valid ? pc_mem_q[rd_q] : '0;
        instrF         = fwd ? imem.imem_rdata : head_valid ? ins_mem_q[rd_q] : '0;
        PCPlus4F       = validF ? PCF + FOUR : '0;
        fetch_pc_d     = accept ? fetch_pc_q + FOUR : fetch_pc_q;
        resp_pc_d      = keep ? resp_pc_q + FOUR : resp_pc_q;
        out_d          = out_q + CW'(accept) - CW'(resp);
        drop_d         = drop_q - CW'(resp && (drop_q != '0));
        wr_d           = wr_q + AW'(push);
        rd_d           = rd_q + AW'(pop);
        count_d        = count_q + CW'(push) - CW'(pop);
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_d     = out_q - CW'(resp);
            wr_d       = '0;
            rd_d       = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_q]  <= resp_pc_q;
            ins_mem_q[wr_q] <= imem.imem_rdata;
        end
    end

    rvalid_without_request: assert property (@(posedge clk) disable iff (!rst_n) imem.imem_rvalid |-> out_q != '0);
endmodule
